// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: PC, ROM address, {pc, inst} buffer to decode
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_i,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] FULL    = CW'(BUF_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [31:0]   fetch_pc;
  logic [31:0]   buf_pc   [BUF_DEPTH];
  logic [31:0]   buf_inst [BUF_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          redirect_unused;

  // Targets are word aligned; the low bits of redirect_pc are dropped.
  assign redirect_unused = ^redirect_pc[1:0];

  // Push/pop decisions use only the current count, so a pop never frees a slot in the same cycle.
  always_comb begin
    push = !redirect_valid && (count < FULL);
    pop  = (count != '0) && if_ready && !redirect_valid;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc[i]   <= '0;
        buf_inst[i] <= '0;
      end
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        buf_pc[wr_ptr]   <= fetch_pc;
        buf_inst[wr_ptr] <= inst_i;
        wr_ptr           <= wr_ptr + PTR_ONE;
        fetch_pc         <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
    end
  end

  assign inst_addr = fetch_pc;
  assign if_valid  = (count != '0);
  assign if_pc     = if_valid ? buf_pc[rd_ptr]   : 32'h0000_0000;
  assign if_inst   = if_valid ? buf_inst[rd_ptr] : NOP_INST;

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage, directly upstream of the instruction ROM. It owns the program counter, drives the ROM address and captures the returned word together with its PC into a small FIFO. It presents {pc, inst} to decode over a valid/ready handshake, and redirects and flushes on branch/jump requests from execute.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; byte address of the first instruction.
- BUF_DEPTH, 2, fetch buffer entries; power of two, ≥2.
- NOP_INST, 32'h0000_0013, value driven on if_inst while if_valid=0 (addi x0,x0,0).

- clk  in  1  single clock; all state on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  execute requests fetch restart (taken branch, jal, jalr).
- redirect_pc  in  32  restart target; bits [1:0] ignored and forced to 0.
- inst_addr  out  32  byte address to ROM, equal to fetch_pc register.
- inst_i  in  32  ROM read data, combinational from inst_addr in the same cycle.
- if_valid  out  1  head of fetch buffer holds a valid instruction.
- if_ready  in  1  decode accepts the head entry this cycle.
- if_pc  out  32  PC of head entry; 0 when if_valid=0.
- if_inst  out  32  instruction of head entry; NOP_INST when if_valid=0.

## Operation
- State: fetch_pc (32b); circular buffer of BUF_DEPTH × {pc, inst}; wr_ptr and rd_ptr (log2(BUF_DEPTH) bits, wrap modulo BUF_DEPTH); count (0..BUF_DEPTH).
- Reset (rstn=0, async): fetch_pc=RESET_PC, count=0, pointers=0, buffer entries cleared to 0. Outputs: inst_addr=RESET_PC, if_valid=0, if_pc=0, if_inst=NOP_INST.
- push = !redirect_valid && (count < BUF_DEPTH). Push writes {fetch_pc, inst_i} at wr_ptr, advances wr_ptr, and sets fetch_pc += 4 (mod 2^32, 0xFFFF_FFFC wraps to 0).
- pop = if_valid && if_ready && !redirect_valid. Pop advances rd_ptr.
- count_next = count + push − pop. Simultaneous push and pop leaves count unchanged.
- Full (count=BUF_DEPTH): no push, fetch_pc holds, inst_addr stable. A pop in a full cycle frees the slot for the next cycle only; there is no same-cycle bypass.
- Empty: if_valid=0, and if_ready is ignored.
- Redirect has highest priority. When redirect_valid=1:
  - count=0 and wr_ptr=rd_ptr=0.
  - fetch_pc={redirect_pc[31:2],2'b00}.
  - No push and no pop that cycle. A head entry shown with if_valid=1 in that cycle is discarded, not consumed.
  - Buffer contents other than the pointers need not be cleared.
- Back-to-back redirects: each one overrides the previous; only the last target is fetched.
- if_valid is (count != 0), derived from registered state only. if_pc and if_inst are muxed from the head slot or forced to 0/NOP_INST when empty.
- ROM range checking is out of scope; inst_addr is driven unmodified.

## Timing
- Reset release: the first clk edge with rstn=1 pushes RESET_PC. if_valid=1, if_pc=RESET_PC on the following cycle, giving 1-cycle fetch latency.
- Steady state with if_ready=1: one instruction per cycle, count stays 1, if_pc increments by 4 each cycle.
- Decode stall (if_ready=0): the buffer fills within BUF_DEPTH−count cycles, then fetch_pc freezes. Outputs hold their value during the stall.
- Redirect asserted in cycle N:
  - Cycle N+1: if_valid=0 and inst_addr=target.
  - Cycle N+2: if_valid=1 and if_pc=target.
  - Redirect penalty is 2 cycles.
- No combinational path from if_ready or redirect_valid to if_valid, if_pc, if_inst or inst_addr.
- Reset asserted mid-stream clears everything immediately (async). Recovery follows the reset-release rule above.

## Test plan
- Reset/startup: hold rstn=0 for 3 cycles, then release with if_ready=1 and ROM containing distinct words at 0x0, 0x4, 0x8. Required: if_valid rises 1 cycle after release, and the accepted sequence is if_pc = 0x0, 0x4, 0x8 with matching if_inst, one per cycle.
- Stall/fill: with if_ready=0 for 5 cycles starting after the first fetch:
  - count reaches 2 and inst_addr freezes at 0x8.
  - if_pc holds 0x0 throughout the stall.
  - After if_ready=1, the sequence is 0x0, 0x4, 0x8, 0xC with no gap, duplicate or loss.
- Redirect: with streaming at if_pc=0x10 and buffer non-empty, pulse redirect_valid with redirect_pc=0x103 for 1 cycle.
  - Next cycle: if_valid=0 and inst_addr=0x100.
  - Cycle after: if_valid=1, if_pc=0x100.
  - No entry from the old stream is accepted afterwards.
- Redirect while full and stalled: with if_ready=0, count=2, assert redirect_valid and if_ready together targeting 0x40. Required: the head is not consumed, the buffer is flushed, and the next valid is if_pc=0x40.
- Back-to-back redirects: redirect to 0x200, then 0x300 on the next cycle. Required: 0x200 is never presented on if_pc, and the first valid is if_pc=0x300 two cycles after the second redirect.
- PC wrap: redirect to 0xFFFF_FFFC with if_ready=1. Required: if_pc = 0xFFFF_FFFC, then 0x0000_0000.
